// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: stalls branches whose operands are not yet
// forwardable, flushes IF/ID on taken branches/jumps, and keeps stall statistics.
module branch_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             isBranch_ID,
    input  logic             Jump_ID,
    input  logic             BranchTaken_ID,
    input  logic [4:0]       RegRdaddr1_ID,
    input  logic [4:0]       RegRdaddr2_ID,
    input  logic             RegWrite_EX,
    input  logic             MemRead_EX,
    input  logic [4:0]       RegWtaddr_EX,
    input  logic             RegWrite_MEM,
    input  logic             MemRead_MEM,
    input  logic [4:0]       RegWtaddr_MEM,
    input  logic             Stall_ext,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             ID_EX_flush,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic       rem;
    logic [1:0] need;
    logic       stall;
    logic       match_ex;
    logic       match_mem;
    logic       unused_mem_wr;

    // MEM-stage ALU results are forwardable, so the MEM write enable is not needed
    assign unused_mem_wr = RegWrite_MEM;

    assign match_ex  = (RegWtaddr_EX != 5'd0) &&
                       ((RegWtaddr_EX == RegRdaddr1_ID) ||
                        (RegWtaddr_EX == RegRdaddr2_ID));
    assign match_mem = (RegWtaddr_MEM != 5'd0) &&
                       ((RegWtaddr_MEM == RegRdaddr1_ID) ||
                        (RegWtaddr_MEM == RegRdaddr2_ID));

    always_comb begin
        need = 2'd0;
        if (isBranch_ID) begin
            if (MemRead_EX && match_ex)
                need = 2'd2;
            else if (RegWrite_EX && match_ex)
                need = 2'd1;
            else if (MemRead_MEM && match_mem)
                need = 2'd1;
        end
    end

    assign stall       = (state == HOLD) || (need != 2'd0);
    assign PC_stall    = stall;
    assign IF_ID_stall = stall;
    assign ID_EX_flush = stall;
    assign IF_ID_flush = !stall && !Stall_ext &&
                         (Jump_ID || (isBranch_ID && BranchTaken_ID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= 1'b0;
        end else if (!Stall_ext) begin
            case (state)
                IDLE: begin
                    if (need == 2'd2) begin
                        state <= HOLD;
                        rem   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (rem == 1'b0)
                        state <= IDLE;
                    else
                        rem <= rem - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            branch_count <= '0;
            taken_count  <= '0;
        end else if (!Stall_ext) begin
            if (stall)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (isBranch_ID && !stall)
                branch_count <= branch_count + CNT_W'(1);
            if (isBranch_ID && !stall && BranchTaken_ID)
                taken_count <= taken_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed-vector bench for branch_hazard_ctrl with hand-computed expectations.
module tb_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        isBranch_ID, Jump_ID, BranchTaken_ID;
    logic [4:0]  RegRdaddr1_ID, RegRdaddr2_ID;
    logic        RegWrite_EX, MemRead_EX;
    logic [4:0]  RegWtaddr_EX;
    logic        RegWrite_MEM, MemRead_MEM;
    logic [4:0]  RegWtaddr_MEM;
    logic        Stall_ext;
    logic        PC_stall, IF_ID_stall, ID_EX_flush, IF_ID_flush;
    logic [31:0] stall_cycles, branch_count, taken_count;

    int total = 0;
    int bad   = 0;

    branch_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .isBranch_ID(isBranch_ID), .Jump_ID(Jump_ID),
        .BranchTaken_ID(BranchTaken_ID),
        .RegRdaddr1_ID(RegRdaddr1_ID), .RegRdaddr2_ID(RegRdaddr2_ID),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
        .RegWtaddr_EX(RegWtaddr_EX),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM),
        .RegWtaddr_MEM(RegWtaddr_MEM),
        .Stall_ext(Stall_ext),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
        .ID_EX_flush(ID_EX_flush), .IF_ID_flush(IF_ID_flush),
        .stall_cycles(stall_cycles), .branch_count(branch_count),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        isBranch_ID = 0; Jump_ID = 0; BranchTaken_ID = 0;
        RegRdaddr1_ID = 0; RegRdaddr2_ID = 0;
        RegWrite_EX = 0; MemRead_EX = 0; RegWtaddr_EX = 0;
        RegWrite_MEM = 0; MemRead_MEM = 0; RegWtaddr_MEM = 0;
        Stall_ext = 0;
    endtask

    // advance one edge; inputs are changed 1ns after it, checks 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic st, input logic fl);
        check({tag, ".pc"}, 32'(PC_stall), 32'(st));
        check({tag, ".ifid"}, 32'(IF_ID_stall), 32'(st));
        check({tag, ".idex"}, 32'(ID_EX_flush), 32'(st));
        check({tag, ".flush"}, 32'(IF_ID_flush), 32'(fl));
    endtask

    task automatic cnts(input string tag, input int s, input int b,
                        input int t);
        check({tag, ".stalls"}, stall_cycles, 32'(s));
        check({tag, ".branches"}, branch_count, 32'(b));
        check({tag, ".taken"}, taken_count, 32'(t));
    endtask

    initial begin
        clr();
        rst = 1;
        #3;
        outs("rst", 0, 0);
        cnts("rst", 0, 0, 0);
        tick();
        rst = 0;
        tick();
        outs("idle", 0, 0);
        cnts("idle", 0, 0, 0);

        // load in EX on rs=5: two stalls, resolve taken on third cycle
        isBranch_ID = 1; RegRdaddr1_ID = 5;
        MemRead_EX = 1; RegWrite_EX = 1; RegWtaddr_EX = 5;
        #1 outs("ldex.c0", 1, 0);
        tick();
        MemRead_EX = 0; RegWrite_EX = 0; RegWtaddr_EX = 0;
        MemRead_MEM = 1; RegWrite_MEM = 1; RegWtaddr_MEM = 5;
        BranchTaken_ID = 1;
        #1 outs("ldex.c1", 1, 0);
        tick();
        MemRead_MEM = 0; RegWrite_MEM = 0; RegWtaddr_MEM = 0;
        #1 outs("ldex.c2", 0, 1);
        tick();
        clr();
        cnts("ldex", 2, 1, 1);

        // ALU in EX on rt=7, then it moves to MEM (forwardable)
        isBranch_ID = 1; RegRdaddr2_ID = 7;
        RegWrite_EX = 1; RegWtaddr_EX = 7;
        #1 outs("aluex.c0", 1, 0);
        tick();
        RegWrite_EX = 0; RegWtaddr_EX = 0;
        RegWrite_MEM = 1; RegWtaddr_MEM = 7;
        #1 outs("aluex.c1", 0, 0);
        tick();
        clr();
        cnts("aluex", 3, 2, 1);

        // load in MEM on rs=9: one stall
        isBranch_ID = 1; RegRdaddr1_ID = 9;
        MemRead_MEM = 1; RegWrite_MEM = 1; RegWtaddr_MEM = 9;
        #1 outs("ldmem.c0", 1, 0);
        tick();
        MemRead_MEM = 0; RegWrite_MEM = 0; RegWtaddr_MEM = 0;
        #1 outs("ldmem.c1", 0, 0);
        tick();
        clr();
        cnts("ldmem", 4, 3, 1);

        // r0 producer never stalls
        isBranch_ID = 1; BranchTaken_ID = 1;
        MemRead_EX = 1; RegWrite_EX = 1; RegWtaddr_EX = 0;
        #1 outs("r0", 0, 1);
        tick();
        clr();
        cnts("r0", 4, 4, 2);

        // Stall_ext while in HOLD
        isBranch_ID = 1; RegRdaddr1_ID = 3;
        MemRead_EX = 1; RegWrite_EX = 1; RegWtaddr_EX = 3;
        #1 outs("ext.c0", 1, 0);
        tick();
        MemRead_EX = 0; RegWrite_EX = 0; RegWtaddr_EX = 0;
        Stall_ext = 1; BranchTaken_ID = 1;
        for (int i = 0; i < 3; i++) begin
            #1 outs($sformatf("ext.frz%0d", i), 1, 0);
            tick();
        end
        Stall_ext = 0;
        #1 outs("ext.rel", 1, 0);
        cnts("ext.frz", 5, 4, 2);
        tick();
        BranchTaken_ID = 0;
        #1 outs("ext.done", 0, 0);
        cnts("ext.rel", 6, 4, 2);
        tick();
        clr();
        cnts("ext.done", 6, 5, 2);

        // reset pulse mid-HOLD
        isBranch_ID = 1; RegRdaddr2_ID = 12;
        MemRead_EX = 1; RegWrite_EX = 1; RegWtaddr_EX = 12;
        tick();
        MemRead_EX = 0; RegWrite_EX = 0; RegWtaddr_EX = 0;
        #1 outs("hold", 1, 0);
        rst = 1;
        #1 outs("midrst", 0, 0);
        cnts("midrst", 0, 0, 0);
        #1 rst = 0;
        clr();
        tick();

        // jump alone flushes, no branch counted
        Jump_ID = 1;
        #1 outs("jump", 0, 1);
        tick();
        cnts("jump", 0, 0, 0);

        // jump plus not-taken branch: jump flushes, branch counted
        isBranch_ID = 1;
        #1 outs("jmpbr", 0, 1);
        tick();
        clr();
        cnts("jmpbr", 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
